// File: rtl/conv_pkg.sv
// Shared types for the convolution tile sequencer: complex sample, 4x4 tile,
// sequencer state encoding and the default multiplier-array latency.
package conv_pkg;

    localparam int unsigned DATA_W           = 16;
    localparam int unsigned MULT_LATENCY_DEF = 6;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    typedef complex_t [0:3][0:3] tile_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/conv_tile_sequencer_if.sv
// Tile input handshake: one image/kernel tile pair per transfer, in_last closes a group.
interface conv_tile_sequencer_if;
    import conv_pkg::*;

    logic  in_valid;
    logic  in_ready;
    logic  in_last;
    tile_t in_image;
    tile_t in_kernel;

    modport master (
        output in_valid, in_last, in_image, in_kernel,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_image, in_kernel,
        output in_ready
    );

endinterface

// File: rtl/pulse_delay_line.sv
// Fixed-depth shift register that delays a WIDTH-bit pulse vector by DEPTH cycles.
module pulse_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_tile_sequencer.sv
// Feeds image/kernel tiles to the multiplier array and frames accumulation groups.
// Optional TILE_SEQ_PERF_EN adds saturating transfer/stall counters.
module conv_tile_sequencer
    import conv_pkg::*;
#(
    parameter  int unsigned MULT_LATENCY = MULT_LATENCY_DEF,
    parameter  int unsigned MAX_CHANNELS = 256,
    localparam int unsigned CW           = $clog2(MAX_CHANNELS) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    conv_tile_sequencer_if.slave        in_if,
    output tile_t                       out_image,
    output tile_t                       out_kernel,
    output logic                        mult_next,
    output logic                        acc_start,
    output logic                        acc_stop,
    input  logic                        acc_output_valid,
    output logic                        group_done,
    output logic [CW-1:0]               group_len,
    output logic                        overflow_err,
    output logic [31:0]                 perf_tiles,
    output logic [31:0]                 perf_stalls
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CHANNELS);

    seq_state_t    state, state_d;
    logic [CW-1:0] cnt, cnt_inc;
    logic          xfer, hit_max, eff_last, first_xfer;
    logic [1:0]    acc_ctl;

    assign in_if.in_ready = reset && (state != DRAIN);

    always_comb begin
        xfer       = in_if.in_valid && in_if.in_ready;
        cnt_inc    = cnt + CW'(1);
        hit_max    = (cnt_inc == MAX_CNT);
        eff_last   = in_if.in_last || hit_max;
        first_xfer = xfer && (state == IDLE);
        state_d    = state;
        case (state)
            IDLE:    if (xfer) state_d = eff_last ? DRAIN : STREAM;
            STREAM:  if (xfer && eff_last) state_d = DRAIN;
            DRAIN:   if (acc_output_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_image    <= '0;
            out_kernel   <= '0;
            mult_next    <= 1'b0;
            cnt          <= '0;
            group_len    <= '0;
            overflow_err <= 1'b0;
            group_done   <= 1'b0;
        end else begin
            mult_next  <= xfer;
            group_done <= (state == DRAIN) && acc_output_valid;
            if (xfer) begin
                out_image  <= in_if.in_image;
                out_kernel <= in_if.in_kernel;
            end
            // Clearing on the way back to IDLE keeps cnt at 0 for a transfer in the first IDLE cycle.
            if (xfer)                  cnt <= cnt_inc;
            else if (state_d == IDLE)  cnt <= '0;
            if (xfer && eff_last)      group_len <= cnt_inc;
            if (xfer && hit_max && !in_if.in_last) overflow_err <= 1'b1;
        end
    end

    // One extra stage because the tags enter alongside the transfer, a cycle before mult_next.
    pulse_delay_line #(
        .DEPTH (MULT_LATENCY + 1),
        .WIDTH (2)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   ({first_xfer, xfer && eff_last}),
        .dout  (acc_ctl)
    );

    assign acc_start = acc_ctl[1];
    assign acc_stop  = acc_ctl[0];

`ifdef TILE_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_tiles  <= '0;
            perf_stalls <= '0;
        end else begin
            if (xfer && (perf_tiles != '1))
                perf_tiles <= perf_tiles + 32'd1;
            if (in_if.in_valid && !in_if.in_ready && (perf_stalls != '1))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`else
    assign perf_tiles  = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Scoreboard bench for conv_tile_sequencer (MAX_CHANNELS=4, MULT_LATENCY=6).
module tb_conv_tile_sequencer;
    import conv_pkg::*;

    localparam int unsigned LAT  = 6;
    localparam int unsigned MAXC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        acc_output_valid;
    tile_t       out_image, out_kernel;
    logic        mult_next, acc_start, acc_stop, group_done, overflow_err;
    logic [2:0]  group_len;
    logic [31:0] perf_tiles, perf_stalls;

    conv_tile_sequencer_if bus ();

    conv_tile_sequencer #(
        .MULT_LATENCY (LAT),
        .MAX_CHANNELS (MAXC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_if            (bus),
        .out_image        (out_image),
        .out_kernel       (out_kernel),
        .mult_next        (mult_next),
        .acc_start        (acc_start),
        .acc_stop         (acc_stop),
        .acc_output_valid (acc_output_valid),
        .group_done       (group_done),
        .group_len        (group_len),
        .overflow_err     (overflow_err),
        .perf_tiles       (perf_tiles),
        .perf_stalls      (perf_stalls)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned at;
        tile_t       img;
        tile_t       ker;
    } mult_exp_t;

    typedef struct {
        int unsigned at;
        int unsigned len;
        bit          ovf;
    } done_exp_t;

    mult_exp_t   mult_q[$];
    int unsigned start_q[$];
    int unsigned stop_q[$];
    done_exp_t   done_q[$];

    bit          grp_first = 1'b1;
    bit          track_acc = 1'b1;
    int unsigned tiles_sent = 0;
    int unsigned seed = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic tile_t mk_tile(input int unsigned s);
        tile_t t;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                t[i][j].re = 16'(s * 17 + 32'(i * 4 + j));
                t[i][j].im = 16'(s * 5 + 100 - 32'(i) - 32'(j));
            end
        end
        return t;
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_tile(input bit lst, input bit grp_end);
        tile_t       img, ker;
        int unsigned waited;
        img = mk_tile(seed);
        ker = mk_tile(seed + 1000);
        seed++;
        bus.in_image  = img;
        bus.in_kernel = ker;
        bus.in_last   = lst;
        bus.in_valid  = 1'b1;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL handshake: in_ready still %b after %0d cycles, expected 1", bus.in_ready, waited);
        end else begin
            mult_q.push_back('{at: cyc + 1, img: img, ker: ker});
            if (grp_first && track_acc) start_q.push_back(cyc + LAT + 1);
            grp_first = 1'b0;
            if (grp_end) begin
                if (track_acc) stop_q.push_back(cyc + LAT + 1);
                grp_first = 1'b1;
            end
            tiles_sent++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_acc(input bit expect_done, input int unsigned len, input bit ovf);
        acc_output_valid = 1'b1;
        if (expect_done) done_q.push_back('{at: cyc + 1, len: len, ovf: ovf});
        @(negedge clk);
        acc_output_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    mult_exp_t   me;
    done_exp_t   de;
    int unsigned ea;

    always @(negedge clk) begin
        if (mult_next === 1'b1) begin
            checks++;
            if (mult_q.size() == 0) begin
                errors++;
                $display("FAIL mult_next: unexpected pulse in cycle %0d, expected none", cyc);
            end else begin
                me = mult_q.pop_front();
                if (me.at != cyc || out_image !== me.img || out_kernel !== me.ker) begin
                    errors++;
                    $display("FAIL mult_next: cycle %0d image %h, expected cycle %0d image %h", cyc, out_image, me.at, me.img);
                end
            end
        end
        if (acc_start === 1'b1) begin
            checks++;
            if (start_q.size() == 0) begin
                errors++;
                $display("FAIL acc_start: unexpected pulse in cycle %0d, expected none", cyc);
            end else begin
                ea = start_q.pop_front();
                if (ea != cyc) begin
                    errors++;
                    $display("FAIL acc_start: pulse in cycle %0d, expected cycle %0d", cyc, ea);
                end
            end
        end
        if (acc_stop === 1'b1) begin
            checks++;
            if (stop_q.size() == 0) begin
                errors++;
                $display("FAIL acc_stop: unexpected pulse in cycle %0d, expected none", cyc);
            end else begin
                ea = stop_q.pop_front();
                if (ea != cyc) begin
                    errors++;
                    $display("FAIL acc_stop: pulse in cycle %0d, expected cycle %0d", cyc, ea);
                end
            end
        end
        if (group_done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL group_done: unexpected pulse in cycle %0d, expected none", cyc);
            end else begin
                de = done_q.pop_front();
                if (de.at != cyc || 32'(group_len) != de.len || overflow_err !== de.ovf) begin
                    errors++;
                    $display("FAIL group_done: cycle %0d len %0d ovf %b, expected cycle %0d len %0d ovf %b",
                             cyc, group_len, overflow_err, de.at, de.len, de.ovf);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " in_ready"},     64'(bus.in_ready), 0);
        check({tag, " mult_next"},    64'(mult_next), 0);
        check({tag, " acc_start"},    64'(acc_start), 0);
        check({tag, " acc_stop"},     64'(acc_stop), 0);
        check({tag, " group_done"},   64'(group_done), 0);
        check({tag, " overflow_err"}, 64'(overflow_err), 0);
        check({tag, " group_len"},    64'(group_len), 0);
        check({tag, " out_image"},    64'(out_image == '0), 1);
        check({tag, " out_kernel"},   64'(out_kernel == '0), 1);
        check({tag, " perf_tiles"},   64'(perf_tiles), 0);
        check({tag, " perf_stalls"},  64'(perf_stalls), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_last      = 1'b0;
        bus.in_image     = '0;
        bus.in_kernel    = '0;
        acc_output_valid = 1'b0;
        #1 reset = 1'b0;
        wait_cycles(2);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check("idle in_ready", 64'(bus.in_ready), 1);

        // Four back-to-back tiles, last on the fourth
        send_tile(0, 0); send_tile(0, 0); send_tile(0, 0); send_tile(1, 1);
        check("drain in_ready", 64'(bus.in_ready), 0);
        wait_cycles(10);
        check("drain hold in_ready", 64'(bus.in_ready), 0);
        pulse_acc(1, 4, 0);
        check("post-done in_ready", 64'(bus.in_ready), 1);

        // Single-tile group
        send_tile(1, 1);
        wait_cycles(9);
        check("single drain in_ready", 64'(bus.in_ready), 0);
        pulse_acc(1, 1, 0);

        // Stray acc_output_valid in IDLE and STREAM; gaps inside the group
        pulse_acc(0, 0, 0);
        check("idle stray in_ready", 64'(bus.in_ready), 1);
        send_tile(0, 0);
        wait_cycles(2);
        pulse_acc(0, 0, 0);
        check("stream stray in_ready", 64'(bus.in_ready), 1);
        send_tile(0, 0);
        wait_cycles(3);
        send_tile(1, 1);
        check("gap overflow_err", 64'(overflow_err), 0);
        wait_cycles(10);
        pulse_acc(1, 3, 0);

        // Overflow: in_last never set, fourth tile forces DRAIN, fifth stalls
        send_tile(0, 0); send_tile(0, 0); send_tile(0, 0); send_tile(0, 1);
        check("overflow_err set", 64'(overflow_err), 1);
        check("overflow in_ready", 64'(bus.in_ready), 0);
        fork
            send_tile(0, 0);
            begin
                wait_cycles(3);
                pulse_acc(1, 4, 1);
            end
        join
`ifdef TILE_SEQ_PERF_EN
        check("perf_tiles", 64'(perf_tiles), 64'(tiles_sent));
        check("perf_stalls", 64'(perf_stalls), 4);
`else
        check("perf_tiles off", 64'(perf_tiles), 0);
        check("perf_stalls off", 64'(perf_stalls), 0);
`endif
        wait_cycles(10);
        check("overflow sticky", 64'(overflow_err), 1);

        // Clean reset, then reset in the middle of a three-tile group
        #2 reset = 1'b0;
        @(negedge clk);
        check("reset clears overflow", 64'(overflow_err), 0);
        reset = 1'b1;
        grp_first = 1'b1;
        track_acc = 1'b0;
        @(negedge clk);
        send_tile(0, 0); send_tile(0, 0); send_tile(1, 1);
        #2 reset = 1'b0;
        @(negedge clk);
        check_all_zero("midgroup reset");
        wait_cycles(2);
        reset = 1'b1;
        track_acc = 1'b1;
        grp_first = 1'b1;
        wait_cycles(12);

        // Fresh group after reset release
        send_tile(0, 0); send_tile(0, 0); send_tile(0, 0); send_tile(1, 1);
        wait_cycles(10);
        pulse_acc(1, 4, 0);
        wait_cycles(12);

        check("pending mult_next", 64'(mult_q.size()), 0);
        check("pending acc_start", 64'(start_q.size()), 0);
        check("pending acc_stop", 64'(stop_q.size()), 0);
        check("pending group_done", 64'(done_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_tile_sequencer.md
CONV_TILE_SEQUENCER -- requirements
Module: conv_tile_sequencer

Interface
REQ-001 SHALL have parameter MULT_LATENCY, default 6, giving the cycles from mult_next to valid multiplier-array output.
REQ-002 SHALL have parameter MAX_CHANNELS, default 256, giving the maximum tiles per accumulation group; CW = $clog2(MAX_CHANNELS)+1.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 in_valid / in_ready  in / out  1 / 1  tile handshake; transfer occurs when both are high.
REQ-006 in_image, in_kernel  in  complex_t [0:3][0:3]  image tile and kernel tile for one input channel.
REQ-007 in_last  in  1  marks the final channel tile of a group.
REQ-008 out_image, out_kernel  out  complex_t [0:3][0:3]  registered tiles that drive the multiplier array.
REQ-009 mult_next  out  1  one-cycle pulse, coincident with new out_image/out_kernel.
REQ-010 acc_start, acc_stop  out  1  accumulator-array controls.
REQ-011 acc_output_valid  in  1  accumulator-array result-valid.
REQ-012 group_done  out  1  one-cycle pulse when a group's result is valid.
REQ-013 group_len  out  CW  tile count of the last completed group.
REQ-014 overflow_err  out  1  sticky; set when a group is truncated.
REQ-015 perf_tiles, perf_stalls  out  32  performance counters (see Configuration).

Function
REQ-016 SHALL implement the states IDLE, STREAM and DRAIN.
REQ-017 in_ready SHALL be high in IDLE and STREAM, and low in DRAIN.
REQ-018 On transfer, out_image/out_kernel SHALL load the inputs on the next edge, with mult_next high for exactly that cycle.
REQ-019 Outputs SHALL hold their values between transfers.
REQ-020 Transitions SHALL be: IDLE->STREAM on a non-last transfer; IDLE->DRAIN on a last transfer; STREAM->DRAIN on a last transfer; DRAIN->IDLE when acc_output_valid is sampled high.
REQ-021 acc_start SHALL pulse MULT_LATENCY cycles after the mult_next of the first tile of a group.
REQ-022 acc_stop SHALL pulse MULT_LATENCY cycles after the mult_next of the last tile of a group.
REQ-023 For a single-tile group, acc_start and acc_stop SHALL pulse in the same cycle.
REQ-024 The channel counter SHALL clear in IDLE and increment per transfer; group_len SHALL load the final count on entry to DRAIN.
REQ-025 A transfer that brings the count to MAX_CHANNELS with in_last low SHALL be treated as last and SHALL set overflow_err.
REQ-026 overflow_err SHALL clear only on reset.
REQ-027 group_done SHALL pulse in the cycle after acc_output_valid is sampled in DRAIN.
REQ-028 acc_output_valid outside DRAIN SHALL be ignored.
REQ-029 Back-to-back transfers SHALL be supported: one tile per cycle, with no bubble between tiles within a group.

Reset
REQ-030 Asserting reset SHALL force, asynchronously: state IDLE; counters 0; delay lines 0; out_image, out_kernel, group_len, perf_tiles and perf_stalls 0; mult_next, acc_start, acc_stop, group_done and overflow_err 0; in_ready 0 while reset is asserted.
REQ-031 A reset asserted mid-group SHALL suppress every pending acc_start/acc_stop pulse.

Configuration
REQ-032 With TILE_SEQ_PERF_EN defined, perf_tiles SHALL count transfers and perf_stalls SHALL count cycles with in_valid high and in_ready low; both SHALL saturate at 2^32-1.
REQ-033 Without TILE_SEQ_PERF_EN, both ports SHALL remain present and tied to 0, and no counter logic SHALL be generated.

Structure
REQ-034 complex_t, the tile array type, the seq_state_t enum and the MULT_LATENCY default SHALL live in the shared package conv_pkg.
REQ-035 The start/stop alignment SHALL use one sub-module, pulse_delay_line, with parameters DEPTH and WIDTH and the same clk/reset convention; it SHALL be instantiated once with WIDTH=2.

Verification
REQ-036 Group of 4 back-to-back tiles, last on the 4th: mult_next pulses in cycles 1-4; acc_start in cycle 7; acc_stop in cycle 10; group_len=4.
REQ-037 Single tile with in_last=1: acc_start and acc_stop both high in cycle 7; state goes to DRAIN; in_ready stays 0 until acc_output_valid; group_done one cycle later.
REQ-038 MAX_CHANNELS=4 with 5 tiles and in_last never set: 4th tile forces DRAIN; overflow_err=1; 5th tile is stalled; with PERF_EN, perf_stalls increments each stalled cycle.
REQ-039 Reset asserted 3 cycles after the first tile of a 3-tile group: no acc_start/acc_stop is ever emitted; all outputs read 0; after reset release, a new group behaves as in REQ-036.
REQ-040 acc_output_valid pulsed in IDLE and in STREAM: no state change and no group_done; gaps of in_valid=0 within a group: acc_stop still aligns 6 cycles after the last mult_next.
